// File: rtl/md5_bench_pkg.sv
// md5_bench_pkg: shared digest width, collector states and record type
package md5_bench_pkg;
    localparam int HASH_WIDTH = 128;
    localparam int MAX_IDX_WIDTH = 16;
    typedef enum logic [1:0] {IDLE, SCAN, HOLD, FINISH} state_t;
    typedef struct packed {
        logic [MAX_IDX_WIDTH-1:0] index;
        logic [HASH_WIDTH-1:0]    md5;
    } md5_record_t;
endpackage

// File: rtl/rr_pointer.sv
// rr_pointer: wrap-around scan counter over CPU_COUNT cores with clear and enable
module rr_pointer #(
    parameter int CPU_COUNT = 1024,
    parameter int IDX_WIDTH = CPU_COUNT > 1 ? $clog2(CPU_COUNT) : 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 enable,
    output logic [IDX_WIDTH-1:0] ptr
);
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n)
            ptr <= '0;
        else if (clear)
            ptr <= '0;
        else if (enable)
            ptr <= (ptr == IDX_WIDTH'(CPU_COUNT - 1)) ? '0 : ptr + 1'b1;
endmodule

// File: rtl/md5_result_collector.sv
// md5_result_collector: round-robin capture of finished core digests into a valid/ready record stream
module md5_result_collector #(
    parameter int CPU_COUNT  = 1024,
    parameter int HASH_WIDTH = md5_bench_pkg::HASH_WIDTH,
    parameter int IDX_WIDTH  = CPU_COUNT > 1 ? $clog2(CPU_COUNT) : 1
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           start,
    input  logic [CPU_COUNT-1:0]           done_in,
    input  logic [CPU_COUNT*HASH_WIDTH-1:0] md5_in,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [IDX_WIDTH-1:0]           out_index,
    output logic [HASH_WIDTH-1:0]          out_md5,
    output logic [IDX_WIDTH:0]             collected_count,
    output logic                           all_done
);
    import md5_bench_pkg::*;
    state_t                 state;
    logic [CPU_COUNT-1:0]   collected;
    logic [IDX_WIDTH-1:0]   ptr;
    logic                   hit, accept, advance, last;
    assign hit     = state == SCAN && done_in[ptr] && !collected[ptr];
    assign accept  = state == HOLD && out_ready;
    assign advance = !start && ((state == SCAN && !hit) || accept);
    assign last    = collected_count == (IDX_WIDTH + 1)'(CPU_COUNT - 1);
    rr_pointer #(.CPU_COUNT(CPU_COUNT), .IDX_WIDTH(IDX_WIDTH)) u_ptr (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (start),
        .enable  (advance),
        .ptr     (ptr)
    );
    // start overrides everything, including a handshake in the same cycle
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            state           <= IDLE;
            collected       <= '0;
            out_valid       <= 1'b0;
            out_index       <= '0;
            out_md5         <= '0;
            collected_count <= '0;
            all_done        <= 1'b0;
        end else if (start) begin
            state           <= SCAN;
            collected       <= '0;
            collected_count <= '0;
            out_valid       <= 1'b0;
            all_done        <= 1'b0;
        end else begin
            case (state)
                SCAN: if (hit) begin
                    out_md5   <= md5_in[ptr*HASH_WIDTH +: HASH_WIDTH];
                    out_index <= ptr;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: if (accept) begin
                    collected[out_index] <= 1'b1;
                    collected_count      <= collected_count + 1'b1;
                    out_valid            <= 1'b0;
                    all_done             <= last;
                    state                <= last ? FINISH : SCAN;
                end
                default: ;
            endcase
        end
endmodule

// File: tb/tb_md5_result_collector.sv
// tb_md5_result_collector: scoreboard bench for 4-core and 5-core collectors
module tb_md5_result_collector;
    localparam int HW = 128;
    typedef struct packed { logic [2:0] idx; logic [HW-1:0] md5; } rec_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic            start = 1'b0, out_ready = 1'b0;
    logic [3:0]      done_in = '0;
    logic [4*HW-1:0] md5_in = '0;
    logic            out_valid, all_done;
    logic [1:0]      out_index;
    logic [HW-1:0]   out_md5;
    logic [2:0]      collected_count;

    logic            start5 = 1'b0, ready5 = 1'b1;
    logic [4:0]      done5 = '0;
    logic [5*HW-1:0] md5_5 = '0;
    logic            valid5, all_done5;
    logic [2:0]      index5;
    logic [HW-1:0]   md5o5;
    logic [3:0]      count5;

    rec_t q[$], q5[$];
    rec_t exp_r;
    int   checks = 0, errors = 0;

    md5_result_collector #(.CPU_COUNT(4), .HASH_WIDTH(HW)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .done_in(done_in), .md5_in(md5_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index), .out_md5(out_md5),
        .collected_count(collected_count), .all_done(all_done)
    );

    md5_result_collector #(.CPU_COUNT(5), .HASH_WIDTH(HW)) dut5 (
        .clock(clock), .reset_n(reset_n), .start(start5), .done_in(done5), .md5_in(md5_5),
        .out_valid(valid5), .out_ready(ready5), .out_index(index5), .out_md5(md5o5),
        .collected_count(count5), .all_done(all_done5)
    );

    task tick;
        @(posedge clock);
        #1;
    endtask

    task pulse_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task set_md5(input int n, input logic [HW-1:0] v);
        md5_in[n*HW +: HW] = v;
    endtask

    task test_reset;
        reset_n = 1'b0;
        tick;
        tick;
        checks++;
        if ({out_valid, out_index, collected_count, all_done} !== '0) begin
            errors++;
            $display("FAIL reset_ctl got v=%b i=%0d c=%0d a=%b want 0", out_valid, out_index, collected_count, all_done);
        end
        checks++;
        if (out_md5 !== '0) begin
            errors++;
            $display("FAIL reset_md5 got %h want 0", out_md5);
        end
        checks++;
        if ({valid5, count5, all_done5} !== '0) begin
            errors++;
            $display("FAIL reset5 got v=%b c=%0d a=%b want 0", valid5, count5, all_done5);
        end
        reset_n = 1'b1;
        tick;
    endtask

    task test_all_cores;
        for (int n = 0; n < 4; n++) begin
            set_md5(n, HW'(32'hA0 + n));
            q.push_back(rec_t'{3'(n), HW'(32'hA0 + n)});
        end
        done_in = 4'hF;
        out_ready = 1'b1;
        pulse_start;
        for (int c = 0; c < 12 && !all_done; c++) begin
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL all_rec unexpected idx=%0d", out_index);
                end else begin
                    exp_r = q.pop_front();
                    if ({1'b0, out_index} !== exp_r.idx || out_md5 !== exp_r.md5) begin
                        errors++;
                        $display("FAIL all_rec got %0d/%h want %0d/%h", out_index, out_md5, exp_r.idx, exp_r.md5);
                    end
                end
            end
            tick;
        end
        checks++;
        if (all_done !== 1'b1 || collected_count !== 3'd4 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL all_done got a=%b c=%0d v=%b want a=1 c=4 v=0", all_done, collected_count, out_valid);
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL all_missing got %0d pending want 0", q.size());
        end
    endtask

    task test_backpressure;
        logic [HW-1:0] v;
        v = HW'(128'h2222_dead_beef_0002);
        out_ready = 1'b0;
        done_in = 4'b0100;
        set_md5(2, v);
        q.push_back(rec_t'{3'd2, v});
        pulse_start;
        for (int c = 0; c < 10 && !out_valid; c++) tick;
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (out_valid !== 1'b1 || out_index !== 2'd2 || out_md5 !== v) begin
                errors++;
                $display("FAIL bp_hold got v=%b i=%0d m=%h want v=1 i=2 m=%h", out_valid, out_index, out_md5, v);
            end
            tick;
        end
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL bp_rec duplicate idx=%0d", out_index);
                end else begin
                    exp_r = q.pop_front();
                    if ({1'b0, out_index} !== exp_r.idx || out_md5 !== exp_r.md5) begin
                        errors++;
                        $display("FAIL bp_rec got %0d/%h want %0d/%h", out_index, out_md5, exp_r.idx, exp_r.md5);
                    end
                end
            end
            tick;
        end
        checks++;
        if (collected_count !== 3'd1 || all_done !== 1'b0 || q.size() != 0) begin
            errors++;
            $display("FAIL bp_count got c=%0d a=%b pend=%0d want c=1 a=0 pend=0", collected_count, all_done, q.size());
        end
    endtask

    task test_late_done;
        int ord[4] = '{3, 0, 1, 2};
        int n;
        done_in = '0;
        out_ready = 1'b1;
        pulse_start;
        for (int k = 0; k < 4; k++) begin
            n = ord[k];
            set_md5(n, HW'(32'hC0 + n));
            q.push_back(rec_t'{3'(n), HW'(32'hC0 + n)});
            if (n == 3) out_ready = 1'b0;
            done_in[n] = 1'b1;
            if (n == 3) begin
                for (int c = 0; c < 20 && !out_valid; c++) tick;
                set_md5(3, HW'(32'h5555));
                tick;
                tick;
                checks++;
                if (out_valid !== 1'b1 || out_md5 !== HW'(32'hC3)) begin
                    errors++;
                    $display("FAIL late_md5_stable got v=%b m=%h want v=1 m=c3", out_valid, out_md5);
                end
                out_ready = 1'b1;
            end
            for (int c = 0; c < 20; c++) begin
                if (out_valid && out_ready) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL late_rec duplicate idx=%0d", out_index);
                    end else begin
                        exp_r = q.pop_front();
                        if ({1'b0, out_index} !== exp_r.idx || out_md5 !== exp_r.md5) begin
                            errors++;
                            $display("FAIL late_rec got %0d/%h want %0d/%h", out_index, out_md5, exp_r.idx, exp_r.md5);
                        end
                    end
                end
                tick;
            end
            checks++;
            if (all_done !== (k == 3) || collected_count !== 3'(k + 1)) begin
                errors++;
                $display("FAIL late_progress k=%0d got a=%b c=%0d want a=%0d c=%0d", k, all_done, collected_count, k == 3, k + 1);
            end
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL late_missing got %0d pending want 0", q.size());
        end
    endtask

    task test_abort;
        done_in = 4'b0011;
        set_md5(0, HW'(32'hB0));
        set_md5(1, HW'(32'hB1));
        q.push_back(rec_t'{3'd0, HW'(32'hB0)});
        out_ready = 1'b1;
        pulse_start;
        for (int c = 0; c < 10; c++) begin
            if (out_valid && out_ready) begin
                checks++;
                exp_r = q.pop_front();
                if ({1'b0, out_index} !== exp_r.idx || out_md5 !== exp_r.md5) begin
                    errors++;
                    $display("FAIL abort_rec0 got %0d/%h want %0d/%h", out_index, out_md5, exp_r.idx, exp_r.md5);
                end
            end
            tick;
            if (collected_count == 3'd1) begin
                out_ready = 1'b0;
                break;
            end
        end
        for (int c = 0; c < 10 && !out_valid; c++) tick;
        checks++;
        if (out_valid !== 1'b1 || out_index !== 2'd1 || collected_count !== 3'd1) begin
            errors++;
            $display("FAIL abort_hold got v=%b i=%0d c=%0d want v=1 i=1 c=1", out_valid, out_index, collected_count);
        end
        pulse_start;
        checks++;
        if (out_valid !== 1'b0 || collected_count !== 3'd0) begin
            errors++;
            $display("FAIL abort_drop got v=%b c=%0d want v=0 c=0", out_valid, collected_count);
        end
        q.push_back(rec_t'{3'd0, HW'(32'hB0)});
        q.push_back(rec_t'{3'd1, HW'(32'hB1)});
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL abort_rec unexpected idx=%0d", out_index);
                end else begin
                    exp_r = q.pop_front();
                    if ({1'b0, out_index} !== exp_r.idx || out_md5 !== exp_r.md5) begin
                        errors++;
                        $display("FAIL abort_rec got %0d/%h want %0d/%h", out_index, out_md5, exp_r.idx, exp_r.md5);
                    end
                end
            end
            tick;
        end
        checks++;
        if (collected_count !== 3'd2 || q.size() != 0) begin
            errors++;
            $display("FAIL abort_recollect got c=%0d pend=%0d want c=2 pend=0", collected_count, q.size());
        end
    endtask

    task test_reset_mid_hold;
        done_in = 4'b0011;
        out_ready = 1'b1;
        pulse_start;
        for (int c = 0; c < 10; c++) begin
            tick;
            if (collected_count == 3'd1) begin
                out_ready = 1'b0;
                break;
            end
        end
        for (int c = 0; c < 10 && !out_valid; c++) tick;
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || all_done !== 1'b0 || collected_count !== 3'd0) begin
            errors++;
            $display("FAIL rst_async got v=%b a=%b c=%0d want 0 0 0", out_valid, all_done, collected_count);
        end
        tick;
        reset_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick;
            checks++;
            if (out_valid !== 1'b0 || collected_count !== 3'd0) begin
                errors++;
                $display("FAIL rst_idle got v=%b c=%0d want v=0 c=0", out_valid, collected_count);
            end
        end
    endtask

    task test_cpu5;
        for (int n = 0; n < 5; n++) begin
            md5_5[n*HW +: HW] = HW'(32'hE0 + n);
            q5.push_back(rec_t'{3'(n), HW'(32'hE0 + n)});
        end
        done5 = 5'h1F;
        ready5 = 1'b1;
        start5 = 1'b1;
        tick;
        start5 = 1'b0;
        for (int c = 0; c < 20 && !all_done5; c++) begin
            if (valid5 && ready5) begin
                checks++;
                if (q5.size() == 0) begin
                    errors++;
                    $display("FAIL c5_rec unexpected idx=%0d", index5);
                end else begin
                    exp_r = q5.pop_front();
                    if (index5 !== exp_r.idx || md5o5 !== exp_r.md5) begin
                        errors++;
                        $display("FAIL c5_rec got %0d/%h want %0d/%h", index5, md5o5, exp_r.idx, exp_r.md5);
                    end
                end
            end
            tick;
        end
        checks++;
        if (all_done5 !== 1'b1 || count5 !== 4'd5 || q5.size() != 0) begin
            errors++;
            $display("FAIL c5_done got a=%b c=%0d pend=%0d want a=1 c=5 pend=0", all_done5, count5, q5.size());
        end
        // pointer sits at 3 when core 0 rises, so it must wrap 4->0 to find it
        done5 = '0;
        start5 = 1'b1;
        tick;
        start5 = 1'b0;
        tick;
        tick;
        tick;
        done5[0] = 1'b1;
        for (int c = 0; c < 4 && !valid5; c++) tick;
        checks++;
        if (valid5 !== 1'b1 || index5 !== 3'd0 || md5o5 !== HW'(32'hE0)) begin
            errors++;
            $display("FAIL c5_wrap got v=%b i=%0d m=%h want v=1 i=0 m=e0", valid5, index5, md5o5);
        end
        tick;
        checks++;
        if (count5 !== 4'd1 || valid5 !== 1'b0) begin
            errors++;
            $display("FAIL c5_wrap_acc got c=%0d v=%b want c=1 v=0", count5, valid5);
        end
    endtask

    initial begin
        test_reset;
        test_all_cores;
        test_backpressure;
        test_late_done;
        test_abort;
        test_reset_mid_hold;
        test_cpu5;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/md5_result_collector.md
Name: md5_result_collector

Overview:
- Consumer end of the md5calculator result interface (per-core `done` + 128-bit `md5`).
- Scans the `done` flags of all cores round-robin and captures each finished core's digest exactly once.
- Emits captured digests as `(index, md5)` records on a valid/ready stream.
- Raises `all_done` after every core has been drained; replaces ad-hoc per-core polling of `done`/`md5` in the bench top.

Parameters:
- CPU_COUNT, 1024, number of md5calculator cores observed.
- HASH_WIDTH, 128, digest width per core.
- IDX_WIDTH, $clog2(CPU_COUNT) (min 1), width of core index and scan pointer.

Ports:
- clock  in  1  system clock, rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse: clear collected bitmap, begin a new collection round.
- done_in  in  CPU_COUNT  per-core done flag; level, sticky while that core's result is valid.
- md5_in  in  CPU_COUNT*HASH_WIDTH  packed digests; core n occupies bits [n*HASH_WIDTH +: HASH_WIDTH].
- out_valid  out  1  output record valid.
- out_ready  in  1  downstream accepts the record.
- out_index  out  IDX_WIDTH  core number of the record.
- out_md5  out  HASH_WIDTH  digest of that core.
- collected_count  out  IDX_WIDTH+1  records accepted downstream this round.
- all_done  out  1  every core's record accepted this round.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; ptr=0; collected bitmap=0.
  - out_valid=0, out_index=0, out_md5=0, collected_count=0, all_done=0.
- States: IDLE, SCAN, HOLD, FINISH.
- IDLE:
  - Outputs are static.
  - `start` -> SCAN next cycle; bitmap, ptr and collected_count cleared on the same edge.
- SCAN: one core examined per cycle.
  - If `done_in[ptr] && !collected[ptr]`: register `out_md5=md5_in[ptr]` and `out_index=ptr`, set out_valid=1, go to HOLD. out_valid is therefore high one cycle after the qualifying sample.
  - Otherwise ptr = ptr+1, wrapping CPU_COUNT-1 -> 0 (also for non-power-of-2 CPU_COUNT).
- HOLD:
  - out_index/out_md5 are stable while out_valid=1 && !out_ready.
  - On `out_valid && out_ready`: set collected[out_index], collected_count+1, ptr+1 (wrap), out_valid=0 next cycle.
  - Then: if the new count == CPU_COUNT -> FINISH, else -> SCAN.
  - Max throughput is one record per 2 cycles. out_ready high continuously is legal.
- FINISH:
  - all_done=1 and out_valid=0 until `start` or reset.
  - `start` in FINISH behaves as in IDLE and clears all_done on the same edge.
- `start` while in SCAN/HOLD:
  - Aborts the round: out_valid drops next cycle, any unaccepted record is discarded, bitmap/count cleared, state SCAN, ptr=0.
  - `start` wins over a simultaneous handshake, and that record is not counted.
- done_in falling after capture: ignored; the record is already held.
- done_in falling before the scan reaches that core: the core is not captured until done_in rises again.
- md5_in is sampled only in the capture cycle; later changes do not affect the held record.
- Each core is captured at most once per round, regardless of how long done_in stays high.
- reset_n low mid-operation: immediate return to reset values; the pending record is lost.
- Worst-case discovery latency for a newly-done core: CPU_COUNT SCAN cycles plus pending HOLD time.

Decomposition:
- Package md5_bench_pkg:
  - HASH_WIDTH constant.
  - Collector state enum {IDLE, SCAN, HOLD, FINISH}.
  - Packed struct md5_record_t {index, md5}.
- Sub-module rr_pointer: wrap-around scan counter with enable/clear, parameterised by CPU_COUNT.
- Everything else, including the bitmap and output register, stays in md5_result_collector.

Test Plan (CPU_COUNT=4 unless noted):
- Reset, then start; done_in=4'b1111, md5_in[n]=128'hA0+n, out_ready=1:
  - Records must be (0,A0),(1,A1),(2,A2),(3,A3), in that order.
  - all_done=1 and collected_count=4 within 12 cycles of start.
- Backpressure: done_in[2] only, out_ready=0 for 10 cycles:
  - out_valid held with index 2 and its md5 stable.
  - After ready, exactly one record; collected_count=1; all_done stays 0.
- Late/out-of-order done:
  - Raise done_in[3], then [0], then [1], then [2], 20 cycles apart.
  - Each is captured exactly once, no duplicates; all_done after the fourth accept.
  - Change md5_in[3] after its capture; the record keeps the old value.
- Abort: start pulse while HOLD on core 1 with out_ready=0:
  - out_valid=0 next cycle, count=0.
  - Core 1 is re-collected in the new round.
- Reset mid-HOLD: reset_n low for one cycle:
  - Immediately out_valid=0, all_done=0, count=0; state IDLE until start.
- CPU_COUNT=5 (non-power-of-2), all done:
  - ptr wraps 4->0 and never addresses core 5–7.
  - Five records; all_done asserted.
